// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: default constants and the fetch FSM encoding.
package riscv_pkg;

  // addi x0,x0,0 -- presented to decode whenever no instruction is held
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // First fetch address after reset unless the instance overrides it
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch request FSM: IDLE waits for skid space, REQ drives the memory
  // request, WAIT holds the single outstanding request until rvalid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  // Force an address onto a 4-byte boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding register used when decode stalls while a
// fetch response is still arriving.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic        drain,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        full,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  logic        full_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;

  // Occupancy flag: a load and a drain in the same cycle leave it full
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full_reg <= 1'b0;
    end else begin
      full_reg <= load || (full_reg && !drain);
    end
  end

  // Payload captured on load; contents are only meaningful while full
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= 32'h0000_0000;
      instr_reg <= 32'h0000_0000;
    end else if (load) begin
      pc_reg    <= load_pc;
      instr_reg <= load_instr;
    end
  end

  assign full  = full_reg;
  assign pc    = pc_reg;
  assign instr = instr_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory request, an output
// register toward decode, a one-entry skid buffer and redirect handling
// that discards the response of a request already in flight.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_id,
  output logic [31:0] instruction,
  output logic [31:0] pc_if,
  output logic [31:0] pc_plus_4_if,
  output logic        if_valid
);

  riscv_pkg::fetch_state_e state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] req_pc_reg, req_pc_next;
  logic        drop_reg, drop_next;
  logic        out_valid_reg, out_valid_next;
  logic [31:0] out_pc_reg, out_pc_next;
  logic [31:0] out_instr_reg, out_instr_next;

  logic        skid_load;
  logic        skid_drain;
  logic        skid_full;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        skid_full_after;

  logic        granted;
  logic        resp_accept;
  logic        consume;

  // Request only from REQ, and never while reset is asserted so the first
  // request lands in the first cycle after reset.
  assign imem_req    = (state_reg == riscv_pkg::REQ) && !rst;
  assign imem_addr   = fetch_pc_reg;
  assign granted     = imem_req && imem_gnt;
  // A response is kept unless it belongs to a redirected-away request or
  // coincides with a redirect.
  assign resp_accept = (state_reg == riscv_pkg::WAIT) && imem_rvalid
                       && !drop_reg && !redirect_valid;
  assign consume     = out_valid_reg && !stall_id;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .clear      (redirect_valid),
    .load       (skid_load),
    .drain      (skid_drain),
    .load_pc    (req_pc_reg),
    .load_instr (imem_rdata),
    .full       (skid_full),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  // Skid occupancy as it will be after this edge; steers the FSM so a new
  // request only issues when there is room for its response.
  assign skid_full_after = !redirect_valid && (skid_load || (skid_full && !skid_drain));

  // Output register and skid steering: redirect flushes, otherwise the skid
  // entry has priority over a fresh response when decode consumes.
  always_comb begin
    out_valid_next = out_valid_reg;
    out_pc_next    = out_pc_reg;
    out_instr_next = out_instr_reg;
    skid_load      = 1'b0;
    skid_drain     = 1'b0;
    if (redirect_valid) begin
      out_valid_next = 1'b0;
    end else if (consume) begin
      if (skid_full) begin
        out_valid_next = 1'b1;
        out_pc_next    = skid_pc;
        out_instr_next = skid_instr;
        skid_drain     = 1'b1;
        skid_load      = resp_accept;
      end else if (resp_accept) begin
        out_valid_next = 1'b1;
        out_pc_next    = req_pc_reg;
        out_instr_next = imem_rdata;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (resp_accept) begin
      if (!out_valid_reg) begin
        out_valid_next = 1'b1;
        out_pc_next    = req_pc_reg;
        out_instr_next = imem_rdata;
      end else begin
        skid_load = 1'b1;
      end
    end
  end

  // Fetch FSM next state, fetch PC and drop flag; redirect overrides last.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    drop_next     = drop_reg;
    case (state_reg)
      riscv_pkg::IDLE: begin
        if (!skid_full_after) state_next = riscv_pkg::REQ;
      end
      riscv_pkg::REQ: begin
        if (granted) begin
          state_next    = riscv_pkg::WAIT;
          req_pc_next   = fetch_pc_reg;
          fetch_pc_next = fetch_pc_reg + 32'd4;
        end
      end
      riscv_pkg::WAIT: begin
        if (imem_rvalid) begin
          drop_next  = 1'b0;
          state_next = skid_full_after ? riscv_pkg::IDLE : riscv_pkg::REQ;
        end
      end
      default: state_next = riscv_pkg::REQ;
    endcase
    if (redirect_valid) begin
      fetch_pc_next = riscv_pkg::word_align(redirect_pc);
      // Anything granted now or still awaiting rvalid must have its
      // response thrown away; wait for it before issuing the new target.
      if (granted || ((state_reg == riscv_pkg::WAIT) && !imem_rvalid)) begin
        drop_next  = 1'b1;
        state_next = riscv_pkg::WAIT;
      end else begin
        drop_next  = 1'b0;
        state_next = riscv_pkg::REQ;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= riscv_pkg::REQ;
      fetch_pc_reg  <= RESET_PC;
      req_pc_reg    <= RESET_PC;
      drop_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_pc_reg    <= RESET_PC;
      out_instr_reg <= NOP_INSTR;
    end else begin
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      req_pc_reg    <= req_pc_next;
      drop_reg      <= drop_next;
      out_valid_reg <= out_valid_next;
      out_pc_reg    <= out_pc_next;
      out_instr_reg <= out_instr_next;
    end
  end

  assign if_valid     = out_valid_reg;
  assign instruction  = out_valid_reg ? out_instr_reg : NOP_INSTR;
  assign pc_if        = out_pc_reg;
  assign pc_plus_4_if = out_pc_reg + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a randomized memory model answers
// requests, the stimulus pushes expected pcs, and a monitor checks every
// instruction decode consumes.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, stall_id;
  logic [31:0] redirect_pc;
  logic [31:0] instruction, pc_if, pc_plus_4_if;
  logic        if_valid;

  logic        w_req, w_gnt, w_rvalid, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc_if, w_pc_plus_4;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_stall = 1'b0;

  int errors = 0;
  int checks = 0;
  int consumed = 0;
  logic [31:0] exp_q[$];
  int gnt_lo, gnt_hi, rv_lo, rv_hi;

  instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_id(stall_id),
    .instruction(instruction), .pc_if(pc_if), .pc_plus_4_if(pc_plus_4_if),
    .if_valid(if_valid)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .stall_id(w_stall),
    .instruction(w_instr), .pc_if(w_pc_if), .pc_plus_4_if(w_pc_plus_4),
    .if_valid(w_valid)
  );

  // Memory contents: a fixed function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Zero-wait memory for the wrap-around instance
  assign w_gnt = w_req;
  always @(posedge clk) begin
    w_rvalid <= w_req && w_gnt;
    w_rdata  <= mem_word(w_addr);
  end

  // Main memory model: grant after gnt_lo..gnt_hi cycles of request,
  // answer rv_lo..rv_hi cycles after the grant cycle plus one.
  initial begin : memory
    bit          pending;
    logic [31:0] p_addr;
    int          rv_wait, gnt_wait;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    pending = 1'b0; p_addr = 32'h0; rv_wait = 0; gnt_wait = 0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        pending = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; gnt_wait = 0;
      end else begin
        if (imem_rvalid) begin
          imem_rvalid = 1'b0;
          pending = 1'b0;
        end
        if (imem_gnt) begin
          imem_gnt = 1'b0;
          pending = 1'b1;
          rv_wait = $urandom_range(rv_hi, rv_lo);
        end
        if (pending) begin
          if (rv_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(p_addr);
          end else begin
            rv_wait--;
          end
        end
        if (imem_req && !pending) begin
          if (gnt_wait == 0) begin
            imem_gnt = 1'b1;
            p_addr = imem_addr;
            gnt_wait = $urandom_range(gnt_hi, gnt_lo);
          end else begin
            gnt_wait--;
          end
        end
      end
    end
  end

  // Monitor: every instruction decode accepts is compared with the next
  // expected pc and the memory word at that pc.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && if_valid && !stall_id) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc %h expected no output", pc_if);
        end else begin
          e = exp_q.pop_front();
          check("pc_if", pc_if, e);
          check("instruction", instruction, mem_word(e));
          check("pc_plus_4_if", pc_plus_4_if, e + 32'd4);
          consumed++;
          $display("txn %0d pc=%h instr=%h", consumed, pc_if, instruction);
        end
      end
    end
  end

  task automatic load_expected(input logic [31:0] start, input int count);
    exp_q.delete();
    for (int i = 0; i < count; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  initial begin : main
    logic [31:0] addrs[$];
    logic [31:0] waddrs[$];
    int          first_valid, w_first, n, req_cyc, val_cyc;
    logic [31:0] snap_pc, snap_in;

    rst = 1'b1; stall_id = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    gnt_lo = 0; gnt_hi = 0; rv_lo = 0; rv_hi = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 0);
    check("rst_if_valid", 32'(if_valid), 0);
    check("rst_instruction", instruction, NOP);
    check("rst_pc_if", pc_if, 32'h0);
    check("rst_pc_plus_4", pc_plus_4_if, 32'h4);
    check("rst_wrap_pc_plus_4", w_pc_plus_4, 32'h0);

    // Zero-wait fetch straight out of reset
    load_expected(32'h0, 20);
    @(posedge clk); #1; rst = 1'b0;
    first_valid = -1; w_first = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (imem_req) addrs.push_back(imem_addr);
      if (w_req) waddrs.push_back(w_addr);
      if (if_valid && first_valid < 0) begin
        first_valid = k;
        check("first_pc_if", pc_if, 32'h0);
      end
      if (w_valid && !w_first) begin
        w_first = 1;
        check("wrap_first_pc_if", w_pc_if, 32'hFFFF_FFFC);
        check("wrap_first_pc_plus_4", w_pc_plus_4, 32'h0);
      end
    end
    check("if_valid_latency", 32'(first_valid), 2);
    for (int i = 0; i < 3; i++)
      check($sformatf("req_addr_%0d", i), (addrs.size() > i) ? addrs[i] : 32'hDEAD_BEEF, 32'(i * 4));
    check("wrap_second_req_addr", (waddrs.size() > 1) ? waddrs[1] : 32'hDEAD_BEEF, 32'h0);

    // Stall for five cycles while valid
    @(posedge clk); #1; stall_id = 1'b1;
    n = 0;
    @(negedge clk);
    while (!if_valid && n < 20) begin @(negedge clk); n++; end
    check("stall_valid_seen", 32'(if_valid), 1);
    snap_pc = pc_if; snap_in = instruction;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_hold_pc", pc_if, snap_pc);
      check("stall_hold_instr", instruction, snap_in);
      if (i >= 2) check("stall_no_req", 32'(imem_req), 0);
    end
    @(posedge clk); #1; stall_id = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("skid_out_valid", 32'(if_valid), 1);
    check("skid_out_pc", pc_if, snap_pc + 32'd4);
    check("post_stall_req", 32'(imem_req), 1);
    check("post_stall_addr", imem_addr, snap_pc + 32'd8);

    // Redirect while a request is outstanding
    rv_lo = 2; rv_hi = 2;
    repeat (6) @(negedge clk);
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    check("r36_req_seen", 32'(imem_req), 1);
    @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    @(posedge clk); #1; redirect_valid = 1'b0; load_expected(32'h100, 16);
    req_cyc = -1; val_cyc = -1;
    for (int k = 0; k < 30 && val_cyc < 0; k++) begin
      @(negedge clk);
      if (k == 0) check("redir_clears_valid", 32'(if_valid), 0);
      if (imem_req && req_cyc < 0) begin
        req_cyc = k;
        check("redir_req_addr", imem_addr, 32'h100);
      end
      if (if_valid && val_cyc < 0) begin
        val_cyc = k;
        check("redir_first_pc", pc_if, 32'h100);
      end
    end
    check("redir_req_after_drop", 32'(req_cyc >= 2), 1);
    check("redir_valid_after_req", 32'(val_cyc > req_cyc && req_cyc >= 0), 1);

    // Redirect coinciding with rvalid under stall
    n = 0;
    @(negedge clk);
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    check("r37_req_seen", 32'(imem_req), 1);
    repeat (3) begin @(posedge clk); #1; end
    stall_id = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(posedge clk); #1;
    redirect_valid = 1'b0; stall_id = 1'b0; load_expected(32'h200, 16);
    @(negedge clk);
    check("r37_if_valid", 32'(if_valid), 0);
    check("r37_instruction", instruction, NOP);
    check("r37_req", 32'(imem_req), 1);
    check("r37_req_addr", imem_addr, 32'h200);
    n = 0;
    while (!if_valid && n < 20) begin @(negedge clk); n++; end
    check("r37_first_pc", pc_if, 32'h200);

    // Random delays and stalls over 1000 instructions
    gnt_lo = 0; gnt_hi = 4; rv_lo = 0; rv_hi = 4;
    @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
    @(posedge clk); #1; redirect_valid = 1'b0; load_expected(32'h1000, 1008); consumed = 0;
    for (int c = 0; c < 40000 && consumed < 1000; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
      stall_id = ($urandom_range(0, 3) == 0);
    end
    stall_id = 1'b1;
    check("random_txn_count", 32'(consumed >= 1000), 1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL be the instruction driven when no valid instruction is held.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 imem_req  output  1  SHALL request a fetch at imem_addr.
REQ-006 imem_addr  output  32  SHALL carry the fetch address, word-aligned.
REQ-007 imem_gnt  input  1  SHALL accept the request in any cycle where imem_req is high.
REQ-008 imem_rvalid  input  1  SHALL mark imem_rdata valid; it arrives at least one cycle after gnt.
REQ-009 imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-010 redirect_valid  input  1  SHALL signal a taken branch, jump or flush from a later stage.
REQ-011 redirect_pc  input  32  SHALL be the new fetch target.
REQ-012 stall_id  input  1  SHALL mean decode cannot accept the held instruction this cycle.
REQ-013 instruction  output  32  SHALL be the instruction word presented to decode.
REQ-014 pc_if  output  32  SHALL be the address of the presented instruction.
REQ-015 pc_plus_4_if  output  32  SHALL be pc_if+4.
REQ-016 if_valid  output  1  SHALL be high when instruction, pc_if and pc_plus_4_if are valid.

Function
REQ-017 The block SHALL keep at most one memory request outstanding.
REQ-018 The FSM SHALL have three states: IDLE, REQ and WAIT.
- imem_req SHALL be 1 only in REQ.
- REQ SHALL go to WAIT on gnt.
- WAIT SHALL go to REQ on rvalid when the skid buffer is empty after that edge; otherwise it SHALL go to IDLE.
- IDLE SHALL go to REQ when the skid buffer is empty.
REQ-019 imem_addr SHALL hold stable while imem_req is high and gnt is low.
REQ-020 The fetch PC SHALL advance by 4 on gnt, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-021 Output handling SHALL follow the output-register state.
- The output register SHALL be consumed when if_valid=1 and stall_id=0.
- An accepted rvalid SHALL load the output register at that edge if it is empty or being consumed; otherwise it SHALL load a one-entry skid buffer.
- The skid buffer SHALL drain into the output register on the edge where the output register is consumed.
REQ-022 Latency: instruction SHALL be visible with if_valid=1 in the cycle after imem_rvalid. With 0-wait memory, throughput SHALL be one instruction per 2 cycles.
REQ-023 While if_valid=1 and stall_id=1, instruction, pc_if and pc_plus_4_if SHALL hold unchanged.
REQ-024 When if_valid=0, instruction SHALL be NOP_INSTR, and pc_if and pc_plus_4_if SHALL hold their last values.
REQ-025 Redirect SHALL take priority over stall and over rvalid. On redirect_valid:
- if_valid and the skid buffer SHALL clear at that edge.
- The fetch PC SHALL load {redirect_pc[31:2],2'b00}.
- A request that is outstanding or granted SHALL set a drop flag.
REQ-026 Drop flag behaviour:
- While the drop flag is set, the next rvalid SHALL be discarded and SHALL clear the flag.
- No new request SHALL issue until the flag clears.
- An rvalid in the same cycle as redirect SHALL be discarded.
REQ-027 A redirect during REQ without gnt SHALL retarget imem_addr to the new PC from the next cycle. The stability rule in REQ-019 is waived for redirects.
REQ-028 Back-to-back redirects SHALL keep only the last target; the drop flag SHALL remain a single flag.

Reset
REQ-029 At reset, the block SHALL load:
- fetch PC = RESET_PC
- state = REQ
- if_valid = 0
- skid buffer empty
- drop flag = 0
- instruction = NOP_INSTR
- pc_if = RESET_PC
- pc_plus_4_if = RESET_PC+4
REQ-030 imem_req SHALL be 0 in any cycle where rst=1. The first request SHALL appear in the first cycle with rst=0.
REQ-031 A reset with a request in flight SHALL NOT drop the response; memory is reset together with this block.

Structure
REQ-032 The shared package riscv_pkg SHALL hold NOP_INSTR, the default RESET_PC and the fetch-state enumeration.
REQ-033 The skid buffer SHALL be a sub-module, fetch_skid_buf: one-entry {pc, instr} register with full flag, load and drain.

Verification
REQ-034 Reset, 0-wait memory (gnt same cycle, rvalid next cycle) -> imem_addr 0x0, 0x4, 0x8 in successive requests; if_valid rises 2 cycles after rst falls, with pc_if=0x0.
REQ-035 stall_id held for 5 cycles while valid -> outputs stable; one further response lands in the skid buffer; no request issues while the skid buffer is full; on release, the outputs show the skid entry next cycle.
REQ-036 redirect_valid with redirect_pc=0x0000_0102 while in WAIT -> the next rvalid is discarded; the next request address is 0x0000_0100; if_valid stays 0 until that response arrives.
REQ-037 redirect_valid in the same cycle as rvalid and stall_id=1 -> the response is discarded; if_valid=0 next cycle; instruction=0x0000_0013.
REQ-038 RESET_PC=0xFFFF_FFFC -> the second request address is 0x0000_0000; pc_plus_4_if=0x0000_0000 for the first instruction.
REQ-039 Random gnt/rvalid delays of 0-4 cycles and 1000 instructions -> the in-order pc sequence is checked against a reference model; no response is lost or duplicated.
